// File: rtl/AESDefinitions.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : AESDefinitions                                             |
// | Shared AES-128 types, round count, S-box and round constants.        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package AESDefinitions;

  localparam int         AES_NUM_ROUNDS = 10;
  localparam logic [3:0] LAST_ROUND     = 4'(AES_NUM_ROUNDS);

  typedef logic [7:0]    byte_t;
  // Byte 0 sits in the most significant position so hex strings read naturally.
  typedef byte_t [0:3]   word_t;
  typedef word_t [0:3]   roundKey_t;

  // Full S-box, row-major: entry [hi][lo] is at byte position hi*16+lo.
  localparam logic [0:255][7:0] SBOX_FLAT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef INFER_RAM
  // Unpacked tables so synthesis can map the lookups onto ROM.
  typedef byte_t sbox_rom_t [0:15][0:15];

  function automatic sbox_rom_t unpack_sbox();
    sbox_rom_t v;
    for (int h = 0; h < 16; h++) begin
      for (int l = 0; l < 16; l++) begin
        v[h][l] = SBOX_FLAT[h*16 + l];
      end
    end
    return v;
  endfunction

  localparam sbox_rom_t sbox = unpack_sbox();
  localparam byte_t rcon [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
`else
  localparam logic [0:15][0:15][7:0] sbox = SBOX_FLAT;
  localparam logic [1:10][7:0] rcon = {8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                       8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
`endif

endpackage

`default_nettype wire

// File: rtl/sub_word.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : sub_word                                                   |
// | Combinational S-box substitution of each byte of a 32-bit word.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sub_word
  import AESDefinitions::*;
(
  input  word_t i_word,
  output word_t o_word
);

  // High nibble selects the S-box row, low nibble the column.
  for (genvar b = 0; b < 4; b++) begin : g_byte
    assign o_word[b] = sbox[i_word[b][7:4]][i_word[b][3:0]];
  end

endmodule

`default_nettype wire

// File: rtl/round_key_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : round_key_generator                                        |
// | AES-128 key expansion: presents round keys 0..10 one per handshake.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module round_key_generator
  import AESDefinitions::*;
(
  input  logic      clock,
  input  logic      reset,
  input  logic      keyValid,
  input  roundKey_t key,
  output logic      keyReady,
  output roundKey_t roundKey,
  output logic      roundKeyValid,
  output logic [3:0] roundIndex,
  input  logic      roundKeyReady
);

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t     r_state;
  logic       r_keyReady;
  logic       r_valid;
  logic [3:0] r_index;
  roundKey_t  r_roundKey;

  word_t      w_rot;
  word_t      w_sub;
  word_t      w_t;
  logic [3:0] w_rconIdx;
  roundKey_t  w_nextKey;

  // RotWord of the last column feeds the S-box.
  assign w_rot = {r_roundKey[3][1], r_roundKey[3][2], r_roundKey[3][3], r_roundKey[3][0]};

  sub_word u_sub_word (
    .i_word (w_rot),
    .o_word (w_sub)
  );

  // At the last round the next key is never used; clamp to keep the index in range.
  assign w_rconIdx = (r_index == LAST_ROUND) ? LAST_ROUND : r_index + 4'd1;

  // Round constant enters only the first byte of t; all XORs are bytewise.
  always_comb begin
    w_t          = w_sub;
    w_t[0]       = w_sub[0] ^ rcon[w_rconIdx];
    w_nextKey[0] = r_roundKey[0] ^ w_t;
    w_nextKey[1] = r_roundKey[1] ^ w_nextKey[0];
    w_nextKey[2] = r_roundKey[2] ^ w_nextKey[1];
    w_nextKey[3] = r_roundKey[3] ^ w_nextKey[2];
  end

  // Control FSM with registered outputs; a round key moves on each accepted handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_keyReady <= 1'b1;
      r_valid    <= 1'b0;
      r_index    <= 4'd0;
      r_roundKey <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (keyValid) begin
            r_roundKey <= key;
            r_index    <= 4'd0;
            r_valid    <= 1'b1;
            r_keyReady <= 1'b0;
            r_state    <= S_EXPAND;
          end
        end
        S_EXPAND: begin
          // roundKeyValid is always high here, so ready alone means transfer.
          if (roundKeyReady) begin
            if (r_index == LAST_ROUND) begin
              r_valid    <= 1'b0;
              r_keyReady <= 1'b1;
              r_state    <= S_IDLE;
            end else begin
              r_roundKey <= w_nextKey;
              r_index    <= r_index + 4'd1;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_valid    <= 1'b0;
          r_keyReady <= 1'b1;
        end
      endcase
    end
  end

  assign keyReady      = r_keyReady;
  assign roundKeyValid = r_valid;
  assign roundIndex    = r_index;
  assign roundKey      = r_roundKey;

endmodule

`default_nettype wire

// File: tb/tb_round_key_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_round_key_generator                                     |
// | Directed self-checking bench for round_key_generator.                |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_round_key_generator;
  import AESDefinitions::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       keyValid;
  roundKey_t  key;
  logic       keyReady;
  roundKey_t  roundKey;
  logic       roundKeyValid;
  logic [3:0] roundIndex;
  logic       roundKeyReady;

  int checks   = 0;
  int failures = 0;

  logic [127:0] exp_a [0:10];
  logic [127:0] exp_z [0:10];
  localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clock = ~clock;

  round_key_generator dut (
    .clock         (clock),
    .reset         (reset),
    .keyValid      (keyValid),
    .key           (key),
    .keyReady      (keyReady),
    .roundKey      (roundKey),
    .roundKeyValid (roundKeyValid),
    .roundIndex    (roundIndex),
    .roundKeyReady (roundKeyReady)
  );

  task automatic chk_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Present a key for one accepting edge; optionally leave keyValid asserted.
  task automatic accept(input logic [127:0] k, input bit hold);
    key      = k;
    keyValid = 1'b1;
    chk_eq("keyReady_before_accept", keyReady, 1'b1);
    @(posedge clock); #1;
    if (!hold) keyValid = 1'b0;
  endtask

  // Walk rounds 0..10 from the current state; zk selects the all-zero key table.
  task automatic expand(input bit zk, input bit rnd);
    int i   = 0;
    int cyc = 0;
    while (i <= 10 && cyc < 300) begin
      chk_eq("roundKeyValid", roundKeyValid, 1'b1);
      chk_eq("keyReady_busy", keyReady, 1'b0);
      chk_eq("roundIndex", roundIndex, i);
      if (!zk) chk_eq("roundKey_a", roundKey, exp_a[i]);
      else if (i == 0 || i == 1 || i == 10) chk_eq("roundKey_zero", roundKey, exp_z[i]);
      roundKeyReady = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      @(posedge clock); #1;
      if (roundKeyReady) i++;
      cyc++;
    end
    if (i <= 10) chk_eq("expand_timeout", i, 11);
    chk_eq("done_valid", roundKeyValid, 1'b0);
    chk_eq("done_keyReady", keyReady, 1'b1);
    chk_eq("done_hold_key", roundKey, zk ? exp_z[10] : exp_a[10]);
  endtask

  initial begin
    exp_a[0]  = KEY_A;
    exp_a[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    exp_a[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    exp_a[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    exp_a[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    exp_a[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    exp_a[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    exp_a[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    exp_a[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    exp_a[9]  = 128'hac7766f319fadc2128d12941575c006e;
    exp_a[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    for (int j = 0; j <= 10; j++) exp_z[j] = '0;
    exp_z[1]  = 128'h62636363626363636263636362636363;
    exp_z[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    reset         = 1'b1;
    keyValid      = 1'b0;
    key           = '0;
    roundKeyReady = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk_eq("rst_valid", roundKeyValid, 1'b0);
    chk_eq("rst_index", roundIndex, 4'd0);
    chk_eq("rst_key", roundKey, 128'h0);
    reset = 1'b0;
    @(posedge clock); #1;
    chk_eq("post_rst_keyReady", keyReady, 1'b1);
    chk_eq("post_rst_valid", roundKeyValid, 1'b0);

    // FIPS-197 key, downstream always ready.
    accept(KEY_A, 1'b0);
    expand(1'b0, 1'b0);

    // Same key with random backpressure.
    accept(KEY_A, 1'b0);
    expand(1'b0, 1'b1);

    // keyValid held with a different key during expansion, then taken back-to-back.
    accept(KEY_A, 1'b1);
    key = '0;
    expand(1'b0, 1'b0);
    @(posedge clock); #1;
    keyValid = 1'b0;
    expand(1'b1, 1'b0);

    // Asynchronous reset in the middle of an expansion.
    accept(KEY_A, 1'b0);
    roundKeyReady = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    chk_eq("mid_index5", roundIndex, 4'd5);
    chk_eq("mid_key5", roundKey, exp_a[5]);
    roundKeyReady = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk_eq("async_rst_valid", roundKeyValid, 1'b0);
    chk_eq("async_rst_index", roundIndex, 4'd0);
    chk_eq("async_rst_key", roundKey, 128'h0);
    // Reset and keyValid on the same edge: reset wins.
    key      = KEY_A;
    keyValid = 1'b1;
    @(posedge clock); #1;
    chk_eq("rst_beats_key_valid", roundKeyValid, 1'b0);
    reset    = 1'b0;
    keyValid = 1'b0;
    @(posedge clock); #1;
    chk_eq("no_key_after_rst", roundKeyValid, 1'b0);
    chk_eq("no_key_after_rst_rk", roundKey, 128'h0);
    accept(KEY_A, 1'b0);
    expand(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/round_key_generator.md
ROUND_KEY_GENERATOR -- requirements
Module: round_key_generator

Interface
- REQ-001 The block SHALL have no parameters; round count comes from the package constant AES_NUM_ROUNDS = 10 (AES-128 only).
- REQ-002 clock  input  1  single clock for the block; all state changes on its rising edge.
- REQ-003 reset  input  1  asynchronous, active-high reset.
- REQ-004 keyValid  input  1  cipher key present on key.
- REQ-005 key  input  roundKey_t (128)  cipher key; byte 0 is the first byte of column 0.
- REQ-006 keyReady  output  1  block can accept a new cipher key.
- REQ-007 roundKey  output  roundKey_t (128)  current round key.
- REQ-008 roundKeyValid  output  1  roundKey and roundIndex are valid.
- REQ-009 roundIndex  output  4  round number of roundKey, 0..10.
- REQ-010 roundKeyReady  input  1  downstream round stage accepts roundKey this cycle.

Function
- REQ-011 The block SHALL implement a two-state FSM: IDLE, EXPAND.
- REQ-012 In IDLE: keyReady=1, roundKeyValid=0; on a clock edge with keyValid=1 -> latch key into roundKey, roundIndex=0, roundKeyValid=1, go to EXPAND.
- REQ-013 Latency: round key 0 SHALL be valid in the cycle immediately after the accepting edge.
- REQ-014 In EXPAND: keyReady=0; keyValid SHALL be ignored.
- REQ-015 Transfer occurs on an edge with roundKeyValid=1 and roundKeyReady=1; without a transfer roundKey and roundIndex SHALL hold.
- REQ-016 On a transfer with roundIndex<10: roundKey <= next key, roundIndex increments by 1; one new key per transfer, no bubbles.
- REQ-017 On a transfer with roundIndex=10: roundKeyValid=0, go to IDLE. keyReady rises in the following cycle. Exactly 11 transfers occur per key.
- REQ-018 Next key: words w0..w3 are bytes 0-3, 4-7, 8-11, 12-15.
- REQ-019 Next key: t = SubWord(RotWord(w3)) XOR {Rcon[roundIndex+1],00,00,00}.
- REQ-020 Next key: w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- REQ-021 RotWord SHALL map bytes [a,b,c,d] -> [b,c,d,a].
- REQ-022 SubWord SHALL index sbox[byte[7:4]][byte[3:0]] per byte.
- REQ-023 Rcon[1..10] SHALL be 01,02,04,08,10,20,40,80,1B,36.
- REQ-024 All XORs SHALL be 8-bit with no carry.
- REQ-025 roundIndex SHALL never exceed 10; no wrap-around.
- REQ-026 roundKey SHALL be unchanged while roundKeyValid=0 (holds last key, not X).

Reset
- REQ-027 Reset SHALL force: state=IDLE, keyReady=1 after release, roundKeyValid=0, roundIndex=0, roundKey=all zero.
- REQ-028 Reset asserted mid-EXPAND SHALL abort the expansion immediately and asynchronously; no further key is presented until a new key is accepted.
- REQ-029 Reset asserted on the same edge as keyValid=1 SHALL win; the key is not accepted.

Structure
- REQ-030 AES_NUM_ROUNDS, the Rcon table (logic [1:10][7:0] rcon) and a word_t typedef (byte_t [0:3]) SHALL live in the shared AESDefinitions package, guarded by the existing INFER_RAM convention like sbox.
- REQ-031 Sub-module sub_word SHALL implement the combinational 4-byte sbox lookup using the package sbox.
- REQ-032 The FSM, registers and XOR network SHALL be in round_key_generator.

Verification
- REQ-033 Key 2b7e151628aed2a6abf7158809cf4f3c, roundKeyReady held 1 -> indices 0..10 on 11 consecutive cycles; round 1 = a0fafe1788542cb123a339392a6c7605; round 2 = f2c295f27a96b9435935807a7359f67f; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- REQ-034 All-zero key -> round 1 = 62636363626363636263636362636363; round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- REQ-035 Same key as REQ-033 with roundKeyReady toggled randomly -> roundKey/roundIndex hold while ready=0; sequence identical to REQ-033.
- REQ-036 keyValid=1 with a different key during EXPAND -> ignored; keyReady=0; expansion output unchanged.
- REQ-037 Reset asserted at roundIndex=5 -> roundKeyValid=0, roundIndex=0, roundKey=0 without a clock edge; a new key afterwards expands correctly from round 0.
- REQ-038 Back-to-back keys: keyValid held 1 -> second key accepted in the first IDLE cycle after round 10 transfer; its round 0 appears the next cycle.
